// File: rtl/core_tick_pkg.sv
// Shared definitions for the core tick scheduler: per-core state encoding and core count.
package core_tick_pkg;

  localparam int NUM_CORES = 2;

  typedef enum logic [1:0] {
    HALTED   = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2
  } core_state_t;

endpackage

// File: rtl/tick_divider.sv
// Programmable slow-tick divider: counts 0..div_max and emits a registered one-cycle tick.
// A config load restarts the count and suppresses the tick for that cycle.
module tick_divider #(
  parameter int DIV_W       = 16,
  parameter int DIV_MAX_RST = 19999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      div_max <= DIV_W'(DIV_MAX_RST);
      tick    <= 1'b0;
    end else if (cfg_we) begin
      cnt     <= '0;
      div_max <= cfg_div;
      tick    <= 1'b0;
    end else if (cnt == div_max) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/core_tick_sched.sv
// Per-core run/halt/step clock-enable scheduler driven by a shared divided tick.
// Optional enable counters are built when CORE_TICK_SCHED_PERF_EN is defined.
module core_tick_sched
  import core_tick_pkg::*;
#(
  parameter int DIV_MAX_RST = 19999,
  parameter int DIV_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic                 alt_mode,
  input  logic [NUM_CORES-1:0] run_req,
  input  logic [NUM_CORES-1:0] halt_req,
  input  logic [NUM_CORES-1:0] step_req,
  output logic [NUM_CORES-1:0] core_en,
  output logic [3:0]           core_state,
  output logic                 tick
`ifdef CORE_TICK_SCHED_PERF_EN
  ,
  output logic [31:0]          en_cnt0,
  output logic [31:0]          en_cnt1
`endif
);

  core_state_t          state_q [NUM_CORES];
  core_state_t          state_d [NUM_CORES];
  logic [NUM_CORES-1:0] elig;
  logic [NUM_CORES-1:0] grant;
  logic                 rr_ptr;
  logic                 rr_nxt;

  tick_divider #(
    .DIV_W       (DIV_W),
    .DIV_MAX_RST (DIV_MAX_RST)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .cfg_we  (cfg_we),
    .cfg_div (cfg_div),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) state_q[i] <= HALTED;
      rr_ptr  <= 1'b0;
      core_en <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) state_q[i] <= state_d[i];
      rr_ptr  <= rr_nxt;
      core_en <= grant;
    end
  end

  // A halt in the same cycle as a tick removes the core from arbitration.
  always_comb begin
    grant  = '0;
    rr_nxt = rr_ptr;
    for (int i = 0; i < NUM_CORES; i++)
      elig[i] = (state_q[i] != HALTED) && !halt_req[i];
    if (tick) begin
      if (!alt_mode) begin
        grant = elig;
      end else if (elig[rr_ptr]) begin
        grant[rr_ptr] = 1'b1;
        rr_nxt        = ~rr_ptr;
      end else if (elig[~rr_ptr]) begin
        grant[~rr_ptr] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        HALTED: begin
          if (halt_req[i])      state_d[i] = HALTED;
          else if (step_req[i]) state_d[i] = STEPPING;
          else if (run_req[i])  state_d[i] = RUNNING;
        end
        RUNNING: begin
          if (halt_req[i]) state_d[i] = HALTED;
        end
        STEPPING: begin
          if (halt_req[i])     state_d[i] = HALTED;
          else if (run_req[i]) state_d[i] = RUNNING;
          else if (grant[i])   state_d[i] = HALTED;
        end
        default: state_d[i] = HALTED;
      endcase
    end
  end

  always_comb begin
    core_state = '0;
    for (int i = 0; i < NUM_CORES; i++)
      core_state[2*i +: 2] = state_q[i];
  end

`ifdef CORE_TICK_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_cnt0 <= '0;
      en_cnt1 <= '0;
    end else begin
      en_cnt0 <= en_cnt0 + 32'(core_en[0]);
      en_cnt1 <= en_cnt1 + 32'(core_en[1]);
    end
  end
`endif

endmodule

// File: tb/tb_core_tick_sched.sv
// Directed bench for core_tick_sched with a rule-level reference model checked every cycle.
module tb_core_tick_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_div = '0;
  logic        alt_mode = 1'b0;
  logic [1:0]  run_req = '0;
  logic [1:0]  halt_req = '0;
  logic [1:0]  step_req = '0;
  logic [1:0]  core_en;
  logic [3:0]  core_state;
  logic        tick;
`ifdef CORE_TICK_SCHED_PERF_EN
  logic [31:0] en_cnt0;
  logic [31:0] en_cnt1;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  core_tick_sched #(.DIV_MAX_RST(3), .DIV_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_div    (cfg_div),
    .alt_mode   (alt_mode),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .core_en    (core_en),
    .core_state (core_state),
    .tick       (tick)
`ifdef CORE_TICK_SCHED_PERF_EN
    ,
    .en_cnt0    (en_cnt0),
    .en_cnt1    (en_cnt1)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: period counter, per-core mode as int, round-robin pointer as int.
  int         m_cnt, m_div, m_rr, m_c0, m_c1;
  int         m_st [2];
  logic       m_tick;
  logic [1:0] m_en, g, el;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_div = 3; m_rr = 0; m_c0 = 0; m_c1 = 0;
      m_st[0] = 0; m_st[1] = 0; m_tick = 0; m_en = 0;
      cyc = 0;
    end else begin
      cyc++;
      m_c0 += int'(m_en[0]);
      m_c1 += int'(m_en[1]);
      for (int i = 0; i < 2; i++) el[i] = (m_st[i] != 0) && !halt_req[i];
      g = 0;
      if (m_tick) begin
        if (!alt_mode) g = el;
        else if (el[m_rr]) g[m_rr] = 1'b1;
        else if (el[1-m_rr]) g[1-m_rr] = 1'b1;
        if (alt_mode && g != 0) m_rr = g[0] ? 1 : 0;
      end
      for (int i = 0; i < 2; i++) begin
        if (halt_req[i]) m_st[i] = 0;
        else if (m_st[i] == 0 && step_req[i]) m_st[i] = 2;
        else if (m_st[i] != 1 && run_req[i]) m_st[i] = 1;
        else if (m_st[i] == 2 && g[i]) m_st[i] = 0;
      end
      if (cfg_we) begin
        m_tick = 0; m_div = int'(cfg_div); m_cnt = 0;
      end else begin
        m_tick = (m_cnt == m_div);
        m_cnt  = m_tick ? 0 : m_cnt + 1;
      end
      m_en = g;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("tick", int'(tick), int'(m_tick));
      check("core_en", int'(core_en), int'(m_en));
      check("core_state", int'(core_state), m_st[1] * 4 + m_st[0]);
`ifdef CORE_TICK_SCHED_PERF_EN
      check("en_cnt0", int'(en_cnt0), m_c0);
      check("en_cnt1", int'(en_cnt1), m_c1);
`endif
    end
  end

  task automatic req(input int kind, input logic [1:0] v);
    case (kind)
      0: run_req = v;
      1: halt_req = v;
      default: step_req = v;
    endcase
    @(negedge clk);
    run_req = 0; halt_req = 0; step_req = 0;
  endtask

  task automatic load_div(input logic [15:0] v);
    cfg_we = 1'b1; cfg_div = v;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    int k = 0;
    while (!tick && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(name, int'(tick), 1);
  endtask

  initial begin
    int first, n0, n1, nb;
    logic [1:0] prev;

    repeat (2) @(negedge clk);
    check("reset core_en", int'(core_en), 0);
    check("reset tick", int'(tick), 0);
    check("reset core_state", int'(core_state), 0);

    // Core0 running at reset divider 3: period 4, first enable 5 cycles after release.
    reset = 1'b0;
    req(0, 2'b01);
    first = -1; n0 = 0; n1 = 0;
    for (int k = 0; k < 19; k++) begin
      if (core_en[0]) begin
        if (first < 0) first = cyc;
        n0++;
      end
      if (core_en[1]) n1++;
      @(negedge clk);
    end
    check("t1 first enable cycle", first, 5);
    check("t1 core0 pulses", n0, 4);
    check("t1 core1 pulses", n1, 0);

    // Alternate mode, both running, tick every 2 cycles.
    alt_mode = 1'b1;
    cfg_we = 1'b1; cfg_div = 16'd1; run_req = 2'b11;
    @(negedge clk);
    cfg_we = 1'b0; run_req = 0;
    repeat (4) @(negedge clk);
    n0 = 0; nb = 0; prev = 2'b00;
    for (int k = 0; k < 12; k++) begin
      if (core_en != 0) begin
        n0++;
        if (!(core_en == 2'b01 || core_en == 2'b10) || core_en == prev) nb++;
        prev = core_en;
      end
      @(negedge clk);
    end
    check("t2 alt pulses", n0, 6);
    check("t2 alt pattern errors", nb, 0);

    alt_mode = 1'b0;
    repeat (3) @(negedge clk);
    n0 = 0; nb = 0;
    for (int k = 0; k < 8; k++) begin
      if (core_en != 0) begin
        n0++;
        if (core_en != 2'b11) nb++;
      end
      @(negedge clk);
    end
    check("t2 shared pulses", n0, 4);
    check("t2 shared pattern errors", nb, 0);

    // Single step on core1, twice.
    req(1, 2'b11);
    repeat (4) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      req(2, 2'b10);
      n0 = 0; n1 = 0;
      for (int k = 0; k < 8; k++) begin
        if (core_en[1]) begin
          n1++;
          check("t3 state halted with pulse", int'(core_state[3:2]), 0);
        end
        if (core_en[0]) n0++;
        @(negedge clk);
      end
      check("t3 step pulses core1", n1, 1);
      check("t3 core0 idle", n0, 0);
      check("t3 core1 halted", int'(core_state[3:2]), 0);
    end

    // Step request landing on a tick waits for the following tick.
    wait_tick("t3b tick seen");
    req(2, 2'b01);
    check("t3b no enable on step tick", int'(core_en[0]), 0);
    n0 = 0;
    for (int k = 0; k < 6; k++) begin
      if (core_en[0]) n0++;
      @(negedge clk);
    end
    check("t3b step pulses", n0, 1);

    // Halt coinciding with tick.
    req(0, 2'b01);
    repeat (3) @(negedge clk);
    wait_tick("t4 tick seen");
    req(1, 2'b01);
    check("t4 no enable on halt tick", int'(core_en[0]), 0);
    check("t4 core0 halted", int'(core_state[1:0]), 0);
    n0 = 0;
    for (int k = 0; k < 8; k++) begin
      if (core_en[0]) n0++;
      @(negedge clk);
    end
    check("t4 later pulses", n0, 0);

    // Divider reload to 0 mid-count.
    load_div(16'd3);
    req(0, 2'b01);
    repeat (2) @(negedge clk);
    load_div(16'd0);
    check("t5 no tick after load", int'(tick), 0);
    repeat (2) @(negedge clk);
    n0 = 0;
    for (int k = 0; k < 6; k++) begin
      if (tick && core_en[0]) n0++;
      @(negedge clk);
    end
    check("t5 every-cycle enables", n0, 6);

    #2 reset = 1'b1;
    #1;
    check("t5 async reset core_en", int'(core_en), 0);
    check("t5 async reset tick", int'(tick), 0);
    check("t5 async reset state", int'(core_state), 0);
    @(negedge clk);
    reset = 1'b0;

`ifdef CORE_TICK_SCHED_PERF_EN
    req(0, 2'b11);
    n0 = 0;
    for (int k = 0; k < 100 && n0 < 10; k++) begin
      @(negedge clk);
      if (core_en == 2'b11) n0++;
    end
    check("t6 shared pulses seen", n0, 10);
    @(negedge clk);
    check("t6 en_cnt0", int'(en_cnt0), 10);
    check("t6 en_cnt1", int'(en_cnt1), 10);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_tick_sched.md
# core_tick_sched

Clock-enable scheduler for the dual-core CPU. It owns the shared slow tick: a programmable divider, default 20 000 cycles. It turns that tick into per-core one-cycle enable pulses, controlled by a run / halt / single-step state machine per core. It sits between the top-level debug/control logic and the two core instances, and replaces a free-running enable with one that can be halted, stepped and shared.

## Interface
Parameters:
- `DIV_MAX_RST`, default 19999: reset value of the divider terminal count (tick period = value + 1 cycles).
- `DIV_W`, default 16: width of the divider count and config value.

Ports:
- `clk`, input, 1: single system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `cfg_we`, input, 1: load `cfg_div` into the divider terminal-count register.
- `cfg_div`, input, `DIV_W`: new terminal count.
- `alt_mode`, input, 1: 0 = shared (both eligible cores enabled on the same tick); 1 = alternate (round-robin, one core per tick).
- `run_req`, input, 2: per-core run request, one-cycle pulse.
- `halt_req`, input, 2: per-core halt request, one-cycle pulse.
- `step_req`, input, 2: per-core single-step request, one-cycle pulse.
- `core_en`, output, 2: per-core clock enable, one-cycle pulse.
- `core_state`, output, 4: 2 bits per core, [1:0] = core0; encoding HALTED=0, RUNNING=1, STEPPING=2.
- `tick`, output, 1: registered divider tick, for debug.
- `en_cnt0`, `en_cnt1`, output, 32 each: enable counters; present only with `CORE_TICK_SCHED_PERF_EN`.

## Operation
Divider:
- `cnt` counts 0..`div_max`.
- At `cnt == div_max`, `cnt` returns to 0 and `tick` is asserted for the next cycle.
- `div_max = 0` gives a tick every cycle.
- `cfg_we` loads `div_max`, clears `cnt` to 0 and suppresses any tick in that cycle.

Per-core FSM, priority halt > step > run, evaluated every cycle:
- HALTED: `step_req` -> STEPPING; `run_req` -> RUNNING.
- RUNNING: `halt_req` -> HALTED. `step_req` and `run_req` are ignored.
- STEPPING: `halt_req` -> HALTED with the step cancelled; `run_req` -> RUNNING; a granted enable -> HALTED.

Eligibility and grant:
- A core is eligible when it is in RUNNING or STEPPING and has no `halt_req` in that cycle.
- Grant is evaluated only in cycles where `tick` = 1.
- Shared mode: every eligible core is granted.
- Alternate mode: the core at `rr_ptr` is granted if eligible, otherwise the other core. `rr_ptr` moves to the non-granted core after each grant; if only one core is eligible, it receives every tick.

`core_en` = grant vector, registered.

## Timing
Reset values:
- `core_en` = 0, `tick` = 0, `cnt` = 0, `div_max` = `DIV_MAX_RST`.
- Both cores HALTED, `rr_ptr` = 0, counters = 0.

Latency:
- After reset release with a core RUNNING, `tick` first asserts at cycle `div_max`+1 and `core_en` at `div_max`+2.
- Steady-state period is `div_max`+1 cycles; `core_en` lags `tick` by exactly 1 cycle.

Simultaneous events:
- `halt_req` coinciding with `tick`: no enable is issued for that core.
- `step_req` arriving in the same cycle as `tick`: no enable on that tick; the first enable comes on the next tick.
- A STEPPING core gets exactly one `core_en` pulse, then reads HALTED in the same cycle that `core_en` is high.

Other rules:
- `alt_mode` changes take effect at the next tick; `rr_ptr` is kept across the change.
- Reset mid-period clears everything immediately, asynchronously; no partial pulse remains.

## Configuration
`CORE_TICK_SCHED_PERF_EN` defined:
- `en_cnt0` / `en_cnt1` count `core_en[0]` / `core_en[1]` pulses, wrap at 2^32 and clear on reset.

Not defined:
- Ports absent and no counter logic; behaviour otherwise identical.

## Structure
- Shared package `core_tick_pkg`: state encoding constants HALTED/RUNNING/STEPPING, the 2-bit state typedef, and `NUM_CORES` = 2.
- One sub-module, `tick_divider`: `cnt`, `div_max` register, `cfg_we` handling, registered `tick` output.
- FSMs, arbitration and counters stay in the top level.

## Test plan
1. Reset, `DIV_MAX_RST`=3, `run_req`=2'b01 -> `core_en[0]` pulses every 4 cycles, first one 5 cycles after reset release; `core_en[1]` stays 0.
2. Both cores RUNNING, `alt_mode`=1, `div_max`=1 -> `core_en` sequence 01, 10, 01, ... every 2 cycles. With `alt_mode`=0 -> 11 every 2 cycles.
3. Core1 HALTED, `step_req[1]` pulse -> exactly one `core_en[1]` pulse at the next tick, then `core_state[3:2]` = 0; a second `step_req` gives exactly one more pulse.
4. Core0 RUNNING, `halt_req[0]` in the same cycle as `tick` -> no `core_en[0]` for that tick, state HALTED, no later pulses.
5. `cfg_we` with `cfg_div`=0 mid-count -> no tick in the load cycle, then `tick` every cycle and a RUNNING core enabled every cycle. Assert `reset` mid-run -> all outputs 0 immediately.
6. With `CORE_TICK_SCHED_PERF_EN`: 10 ticks in shared mode, both cores RUNNING -> `en_cnt0` = `en_cnt1` = 10.
